// File: rtl/metronome_beat_display.sv
// Beat-display driver: beat flash, bar-accent flash and hysteretic tempo-range LED.
// Latency 1 clock from sampled inputs; all outputs registered; no backpressure (event-driven).

module metronome_hold_led #(
    parameter int HOLD_CYCLES = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_fire,
    output logic o_led
);
    localparam int W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [W-1:0] LOAD = W'(HOLD_CYCLES - 1);

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A fire while ON reloads the counter, so back-to-back beats never leave a gap.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!i_enable) begin
            state_d = ST_OFF;
            cnt_d   = '0;
        end else if (i_fire) begin
            state_d = ST_ON;
            cnt_d   = LOAD;
        end else begin
            case (state_q)
                ST_ON: begin
                    if (cnt_q == '0) begin
                        state_d = ST_OFF;
                    end else begin
                        cnt_d = cnt_q - W'(1);
                    end
                end
                default: begin
                    state_d = ST_OFF;
                end
            endcase
        end
    end

    assign o_led = (state_q == ST_ON);
endmodule

module metronome_beat_display #(
    parameter int CNT_W              = 34,
    parameter int IDX_W              = 4,
    parameter int HOLD_CYCLES        = 2_500_000,
    parameter int ACCENT_HOLD_CYCLES = 5_000_000,
    parameter int FAST_THRESH        = 600,
    parameter int FAST_HYST          = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_enable,
    input  logic             i_trigger,
    input  logic             i_sync,
    input  logic [IDX_W-1:0] i_beats_per_bar,
    input  logic [CNT_W-1:0] i_bpm_counter,
    output logic             o_beat_led,
    output logic             o_accent_led,
    output logic             o_fast_led,
    output logic [IDX_W-1:0] o_beat_idx,
    output logic             o_bar_pulse
);
    localparam logic [CNT_W-1:0] THRESH_HI = CNT_W'(FAST_THRESH);
    localparam logic [CNT_W-1:0] THRESH_LO = CNT_W'(FAST_THRESH - FAST_HYST);

    logic             trig_q;
    logic             first_pending_q, first_pending_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             bar_q, bar_d;
    logic             fast_q, fast_d;
    logic [IDX_W-1:0] last_idx;
    logic             beat_ev;
    logic             wrap;
    logic             downbeat;

    assign beat_ev  = i_enable & i_trigger & ~trig_q;
    assign last_idx = (i_beats_per_bar == '0) ? '0 : (i_beats_per_bar - IDX_W'(1));
    // A sync coincident with a beat makes that beat the downbeat.
    assign wrap     = first_pending_q | i_sync | (idx_q >= last_idx);
    assign downbeat = beat_ev & wrap;

    always_comb begin
        first_pending_d = first_pending_q;
        idx_d           = idx_q;
        bar_d           = downbeat;
        if (!i_enable) begin
            first_pending_d = 1'b1;
        end else if (beat_ev) begin
            first_pending_d = 1'b0;
            idx_d           = wrap ? '0 : (idx_q + IDX_W'(1));
        end else if (i_sync) begin
            first_pending_d = 1'b1;
        end
    end

    always_comb begin
        fast_d = fast_q;
        if (!fast_q && (i_bpm_counter >= THRESH_HI)) begin
            fast_d = 1'b1;
        end else if (fast_q && (i_bpm_counter < THRESH_LO)) begin
            fast_d = 1'b0;
        end
    end

    // trig_q resets high so a trigger already asserted at reset release is not a beat.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            trig_q          <= 1'b1;
            first_pending_q <= 1'b1;
            idx_q           <= '0;
            bar_q           <= 1'b0;
            fast_q          <= 1'b0;
        end else begin
            trig_q          <= i_trigger;
            first_pending_q <= first_pending_d;
            idx_q           <= idx_d;
            bar_q           <= bar_d;
            fast_q          <= fast_d;
        end
    end

    metronome_hold_led #(
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_beat_led (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_fire   (beat_ev),
        .o_led    (o_beat_led)
    );

    metronome_hold_led #(
        .HOLD_CYCLES (ACCENT_HOLD_CYCLES)
    ) u_accent_led (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_enable (i_enable),
        .i_fire   (downbeat),
        .o_led    (o_accent_led)
    );

    assign o_fast_led  = fast_q;
    assign o_beat_idx  = idx_q;
    assign o_bar_pulse = bar_q;
endmodule

// File: tb/tb_metronome_beat_display.sv
// Directed bench for metronome_beat_display with HOLD=3, ACCENT=5, THRESH=600, HYST=16.
module tb_metronome_beat_display;
    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        trigger;
    logic        sync;
    logic [3:0]  bpb;
    logic [33:0] bpm;
    logic        beat_led;
    logic        accent_led;
    logic        fast_led;
    logic [3:0]  beat_idx;
    logic        bar_pulse;

    int checks   = 0;
    int failures = 0;

    metronome_beat_display #(
        .CNT_W              (34),
        .IDX_W              (4),
        .HOLD_CYCLES        (3),
        .ACCENT_HOLD_CYCLES (5),
        .FAST_THRESH        (600),
        .FAST_HYST          (16)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_enable        (enable),
        .i_trigger       (trigger),
        .i_sync          (sync),
        .i_beats_per_bar (bpb),
        .i_bpm_counter   (bpm),
        .o_beat_led      (beat_led),
        .o_accent_led    (accent_led),
        .o_fast_led      (fast_led),
        .o_beat_idx      (beat_idx),
        .o_bar_pulse     (bar_pulse)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int nb;
        int na;
        int np;
        int exp_idx;

        rst = 1'b1; enable = 1'b0; trigger = 1'b0; sync = 1'b0;
        bpb = 4'd4; bpm = '0;
        #2;
        chk("rst_beat",   int'(beat_led),   0);
        chk("rst_accent", int'(accent_led), 0);
        chk("rst_fast",   int'(fast_led),   0);
        chk("rst_idx",    int'(beat_idx),   0);
        chk("rst_bar",    int'(bar_pulse),  0);
        tick(); tick();
        rst = 1'b0;
        enable = 1'b1;
        tick(); tick();

        // Nine beats, L=4, 10 cycles apart.
        for (int b = 0; b < 9; b++) begin
            nb = 0; na = 0; np = 0;
            exp_idx = b % 4;
            for (int k = 0; k < 10; k++) begin
                trigger = (k == 0);
                tick();
                if (k == 0) begin
                    chk("t1_idx", int'(beat_idx), exp_idx);
                    chk("t1_lat", int'(beat_led), 1);
                end
                nb += int'(beat_led);
                na += int'(accent_led);
                np += int'(bar_pulse);
            end
            chk("t1_beat_len",   nb, 3);
            chk("t1_accent_len", na, (exp_idx == 0) ? 5 : 0);
            chk("t1_bar_cnt",    np, (exp_idx == 0) ? 1 : 0);
        end

        // Retrigger two cycles after a beat: one continuous 5-cycle flash.
        nb = 0;
        for (int k = 0; k < 11; k++) begin
            trigger = (k == 0) || (k == 2);
            tick();
            if (k >= 1 && k <= 3) chk("t2_nogap", int'(beat_led), 1);
            nb += int'(beat_led);
        end
        chk("t2_len", nb, 5);
        chk("t2_idx", int'(beat_idx), 2);

        // Advance to idx 5 with L=8, then shrink L to 3.
        bpb = 4'd8;
        for (int k = 0; k < 3; k++) begin
            trigger = 1'b1; tick(); trigger = 1'b0; tick();
        end
        chk("t3_idx5", int'(beat_idx), 5);
        bpb = 4'd3;
        trigger = 1'b1; tick();
        chk("t3_shrink_idx", int'(beat_idx), 0);
        chk("t3_shrink_bar", int'(bar_pulse), 1);
        trigger = 1'b0; tick();
        bpb = 4'd0;
        for (int k = 0; k < 2; k++) begin
            trigger = 1'b1; tick();
            chk("t3_l0_idx", int'(beat_idx), 0);
            chk("t3_l0_bar", int'(bar_pulse), 1);
            trigger = 1'b0; tick();
        end

        // Sync strobe between beats, then sync coincident with a beat.
        bpb = 4'd4;
        trigger = 1'b1; tick(); trigger = 1'b0; tick();
        trigger = 1'b1; tick(); trigger = 1'b0; tick();
        chk("t4_idx2", int'(beat_idx), 2);
        for (int k = 0; k < 6; k++) tick();
        sync = 1'b1; tick(); sync = 1'b0;
        chk("t4_sync_hold_idx", int'(beat_idx), 2);
        chk("t4_sync_no_acc",   int'(accent_led), 0);
        trigger = 1'b1; tick();
        chk("t4_sync_idx", int'(beat_idx), 0);
        chk("t4_sync_bar", int'(bar_pulse), 1);
        chk("t4_sync_acc", int'(accent_led), 1);
        trigger = 1'b0; tick();
        trigger = 1'b1; tick(); trigger = 1'b0; tick();
        chk("t4_after_idx", int'(beat_idx), 1);
        sync = 1'b1; trigger = 1'b1; tick();
        chk("t4_coinc_idx", int'(beat_idx), 0);
        chk("t4_coinc_bar", int'(bar_pulse), 1);
        sync = 1'b0; trigger = 1'b0; tick();
        trigger = 1'b1; tick(); trigger = 1'b0;
        chk("t4_next_idx", int'(beat_idx), 1);
        tick();

        // Tempo LED hysteresis.
        bpm = 34'd590; tick(); chk("t5_590_off", int'(fast_led), 0);
        bpm = 34'd599; tick(); chk("t5_599_off", int'(fast_led), 0);
        bpm = 34'd600; tick(); chk("t5_600_on",  int'(fast_led), 1);
        bpm = 34'd590; tick(); chk("t5_590_on",  int'(fast_led), 1);
        bpm = 34'd584; tick(); chk("t5_584_on",  int'(fast_led), 1);
        bpm = 34'd583; tick(); chk("t5_583_off", int'(fast_led), 0);

        // Enable dropped mid-hold with trigger held high.
        for (int k = 0; k < 6; k++) tick();
        trigger = 1'b1; tick();
        chk("t6_beat", int'(beat_led), 1);
        chk("t6_idx",  int'(beat_idx), 2);
        enable = 1'b0; bpm = 34'd600; tick();
        chk("t6_dis_beat", int'(beat_led), 0);
        chk("t6_dis_idx",  int'(beat_idx), 2);
        chk("t6_dis_fast", int'(fast_led), 1);
        enable = 1'b1; tick();
        chk("t6_reen_nobeat", int'(beat_led), 0);
        trigger = 1'b0; tick();
        trigger = 1'b1; tick();
        chk("t6_reen_idx", int'(beat_idx), 0);
        chk("t6_reen_bar", int'(bar_pulse), 1);
        chk("t6_reen_acc", int'(accent_led), 1);

        // Async reset mid-hold, trigger held high through release.
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_beat",   int'(beat_led), 0);
        chk("t7_rst_accent", int'(accent_led), 0);
        chk("t7_rst_fast",   int'(fast_led), 0);
        bpm = '0;
        tick();
        rst = 1'b0;
        tick(); tick();
        chk("t7_held_nobeat", int'(beat_led), 0);
        trigger = 1'b0; tick();
        trigger = 1'b1; tick();
        chk("t7_beat_idx", int'(beat_idx), 0);
        chk("t7_beat_bar", int'(bar_pulse), 1);
        chk("t7_beat_led", int'(beat_led), 1);
        trigger = 1'b0; tick();
        chk("t7_bar_once", int'(bar_pulse), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
